ysyx_22040365_ifu: RTL and testbench
====================================

# ysyx_22040365_ifu

Instruction fetch unit that produces the instruction stream consumed by the single-cycle core's decode/regfile/execute path. It owns the PC and issues one fetch at a time to instruction memory over a valid/ready request and valid-only response channel. It presents each fetched word with its PC to decode over a valid/ready handshake, applies redirects from execute, and stops fetching after delivering `ebreak` (0x00100073) so the top-level `quit()` path fires exactly once.

## Interface

Parameters:
- `RESET_PC`, 64'h0000_0000_8000_0000: first fetch address after reset.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `imem_req_valid`  out  1: fetch request valid.
- `imem_req_ready`  in  1: memory accepts request.
- `imem_req_addr`  out  64: fetch address, 4-byte aligned.
- `imem_rsp_valid`  in  1: response valid, one cycle per accepted request.
- `imem_rsp_data`  in  32: instruction word.
- `imem_rsp_err`  in  1: access fault, qualified by `imem_rsp_valid`.
- `inst_valid`  out  1: instruction available to decode.
- `inst_ready`  in  1: decode consumes instruction.
- `inst`  out  32: instruction word.
- `inst_pc`  out  64: PC of `inst`.
- `redirect_valid`  in  1: one-cycle PC redirect from execute.
- `redirect_pc`  in  64: redirect target.
- `halt`  out  1: sticky; fetch stopped after `ebreak`.
- `fetch_err`  out  1: sticky; fault or misaligned redirect.

## Operation

- States: START, REQ, WAIT, HOLD, DROP, HALT. Reset enters START.
- START: moves to REQ unconditionally.
- REQ: `imem_req_valid`=1 and `imem_req_addr`=pc. On handshake, go to WAIT.
- WAIT: on `imem_rsp_valid`, capture data into the buffer with `inst_pc`=pc and go to HOLD. If `imem_rsp_err`=1, set `fetch_err` and go to HALT with nothing delivered.
- HOLD: `inst_valid`=1. On `inst_ready`:
  - If `inst`==0x00100073, go to HALT and set `halt`.
  - Otherwise set pc to pc+4 (64-bit wrap) and go to REQ.
- Redirects (`redirect_valid`=1) have priority over the sequential update:
  - REQ without a request handshake that cycle: pc=`redirect_pc`, stay in REQ. The address may change while valid is high only in this case; memory samples the address only on handshake.
  - REQ with a handshake that cycle, or WAIT without a response: pc=`redirect_pc`, go to DROP.
  - WAIT with a response the same cycle: discard the response, pc=`redirect_pc`, go to REQ.
  - HOLD: buffered instruction is dropped (if `inst_ready` is also high, the handshake counts as completed). pc=`redirect_pc`, go to REQ. An `ebreak` consumed in the same cycle as a redirect still halts.
  - START: pc=`redirect_pc`, go to REQ.
- Misaligned redirect (`redirect_pc[1:0]`≠0): set `fetch_err`, go to HALT. DROP is not entered; any outstanding response is ignored.
- DROP: discard the next response, including its `imem_rsp_err`. Then go to REQ. A redirect while in DROP updates pc and stays in DROP.
- HALT: all outputs idle, inputs ignored. Leave only via `rst`.
- At most one outstanding request. `imem_rsp_valid` outside WAIT/DROP is ignored.

## Timing

- Reset values, asserted asynchronously:
  - `imem_req_valid`=0, `imem_req_addr`=RESET_PC
  - `inst_valid`=0, `inst`=32'h00000013, `inst_pc`=RESET_PC
  - `halt`=0, `fetch_err`=0
  - internal pc=RESET_PC
- `rst` asserted in any state aborts the operation immediately. The response to a request outstanding at reset is discarded only by memory also being reset; the IFU provides no guarantee for it.
- All outputs are decoded from registered state; there is no combinational input-to-output path.
- Memory rule: `imem_rsp_valid` arrives at the earliest one cycle after the request handshake.
- Best-case latency: handshake in cycle N, response in N+1, `inst_valid` in N+2. Peak rate is one instruction per 3 cycles.
- `inst`/`inst_pc` hold stable while `inst_valid`=1 and `inst_ready`=0.
- `halt` and `fetch_err` rise the cycle after the causing event.

## Test plan

- Reset release, `imem_req_ready`=1, memory returns 0x00000013 at latency 1:
  - requests go to 0x80000000, 0x80000004, 0x80000008;
  - each instruction presented 2 cycles after its handshake with the matching `inst_pc`.
- Backpressure: hold `inst_ready`=0 for 5 cycles in HOLD → `inst` and `inst_pc` stable, no new request; release → next request is at pc+4.
- Redirect to 0x80000100 in WAIT → old response dropped, no `inst_valid` for it, next request is to 0x80000100.
  - Repeat with the redirect in the same cycle as the response → no DROP cycle.
- Deliver 0x00100073 at 0x80000010 → handshake completes, `halt`=1 next cycle, `imem_req_valid` stays 0 for 20 cycles.
- `imem_rsp_err`=1 at 0x80000008 → `fetch_err`=1, no `inst_valid`.
  - Redirect to 0x80000102 → `fetch_err`=1, HALT.
- Assert `rst` mid-WAIT → outputs at reset values the same cycle; first request after release is to 0x80000000.

Source files
------------

// File: rtl/ysyx_22040365_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_22040365_ifu_if
//
// Bundles every handshake and bus signal of the instruction fetch unit:
//   - imem request channel  : imem_req_valid / imem_req_ready / imem_req_addr
//   - imem response channel : imem_rsp_valid / imem_rsp_data / imem_rsp_err
//   - decode channel        : inst_valid / inst_ready / inst / inst_pc
//   - execute redirect      : redirect_valid / redirect_pc
//   - status                : halt / fetch_err (both sticky)
//
// Modports:
//   master : the IFU side (drives the request, decode and status signals)
//   slave  : the environment side (memory, decode and execute)
// ---------------------------------------------------------------------------
interface ysyx_22040365_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        fetch_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    output inst_valid, inst, inst_pc,
    input  inst_ready,
    input  redirect_valid, redirect_pc,
    output halt, fetch_err
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data, imem_rsp_err,
    input  inst_valid, inst, inst_pc,
    output inst_ready,
    output redirect_valid, redirect_pc,
    input  halt, fetch_err
  );
endinterface

// File: rtl/ysyx_22040365_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22040365_ifu
//
// Instruction fetch unit for the single-cycle core. Owns the PC, issues one
// fetch at a time to instruction memory, buffers the returned word and hands
// it with its PC to decode. Execute can redirect the PC at any point; fetch
// stops for good after an ebreak is handed over or after a fault.
//
// Ports:
//   clk     : clock, all state on its rising edge
//   rst     : asynchronous, active-high reset
//   io_ifu  : ysyx_22040365_ifu_if.master bundle
//               imem_req_*   fetch request (valid/ready, 64-bit address)
//               imem_rsp_*   fetch response (valid only, data + error)
//               inst_*       instruction to decode (valid/ready, word + PC)
//               redirect_*   one-cycle PC redirect from execute
//               halt         sticky, set after ebreak is consumed
//               fetch_err    sticky, set on access fault or misaligned redirect
//
// Every output comes straight from a register; no input reaches an output
// within the same cycle.
// ---------------------------------------------------------------------------
module ysyx_22040365_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_22040365_ifu_if.master     io_ifu
);

  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    START,
    REQ,
    WAIT,
    HOLD,
    DROP,
    HALT
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic        r_req_valid;
  logic        r_inst_valid;
  logic [31:0] r_inst;
  logic [63:0] r_inst_pc;
  logic        r_halt;
  logic        r_fetch_err;

  state_t      w_next_state;
  logic [63:0] w_next_pc;
  logic        w_capture;
  logic        w_set_halt;
  logic        w_set_err;
  logic        w_req_hs;
  logic        w_redir_ok;
  logic        w_redir_bad;
  logic        w_ebreak_taken;

  // r_req_valid is high exactly in REQ, so this is the request handshake.
  assign w_req_hs    = r_req_valid & io_ifu.imem_req_ready;
  assign w_redir_ok  = io_ifu.redirect_valid & (io_ifu.redirect_pc[1:0] == 2'b00);
  assign w_redir_bad = io_ifu.redirect_valid & (io_ifu.redirect_pc[1:0] != 2'b00);
  // An ebreak handed to decode halts even if a redirect arrives with it.
  assign w_ebreak_taken = (r_state == HOLD) & io_ifu.inst_ready & (r_inst == EBREAK);

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_set_halt   = 1'b0;
    w_set_err    = 1'b0;

    unique case (r_state)
      START: begin
        w_next_state = REQ;
        if (w_redir_ok) w_next_pc = io_ifu.redirect_pc;
      end

      REQ: begin
        if (w_req_hs) w_next_state = WAIT;
        if (w_redir_ok) begin
          w_next_pc = io_ifu.redirect_pc;
          // Once the request is accepted its response is still coming and
          // must be swallowed; before that the address can simply move.
          w_next_state = w_req_hs ? DROP : REQ;
        end
      end

      WAIT: begin
        if (io_ifu.imem_rsp_valid) begin
          if (io_ifu.imem_rsp_err) begin
            w_set_err    = 1'b1;
            w_next_state = HALT;
          end else begin
            w_next_state = HOLD;
          end
        end
        if (w_redir_ok) begin
          // A redirect discards whatever the response carried, error included.
          w_set_err    = 1'b0;
          w_next_pc    = io_ifu.redirect_pc;
          w_next_state = io_ifu.imem_rsp_valid ? REQ : DROP;
        end
      end

      HOLD: begin
        if (w_ebreak_taken) begin
          w_set_halt   = 1'b1;
          w_next_state = HALT;
        end else if (w_redir_ok) begin
          w_next_pc    = io_ifu.redirect_pc;
          w_next_state = REQ;
        end else if (io_ifu.inst_ready) begin
          w_next_pc    = r_pc + 64'd4;
          w_next_state = REQ;
        end
      end

      DROP: begin
        // The stale response (and its error flag) is consumed here. A
        // redirect only retargets the pc; the drop must still complete.
        if (io_ifu.imem_rsp_valid) w_next_state = REQ;
        if (w_redir_ok) w_next_pc = io_ifu.redirect_pc;
      end

      HALT: begin
        w_next_state = HALT;
      end

      default: begin
        w_next_state = HALT;
      end
    endcase

    // Misaligned redirect target: stop fetching; any outstanding response
    // arrives in HALT and is ignored there.
    if (w_redir_bad && (r_state != HALT)) begin
      w_set_err    = 1'b1;
      w_next_state = HALT;
    end
  end

  assign w_capture = (r_state == WAIT) && (w_next_state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= START;
      r_pc         <= RESET_PC;
      r_req_valid  <= 1'b0;
      r_inst_valid <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_pc    <= RESET_PC;
      r_halt       <= 1'b0;
      r_fetch_err  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_pc         <= w_next_pc;
      // Outputs are registered from the next state so they line up with it.
      r_req_valid  <= (w_next_state == REQ);
      r_inst_valid <= (w_next_state == HOLD);
      if (w_capture) begin
        r_inst    <= io_ifu.imem_rsp_data;
        r_inst_pc <= r_pc;
      end
      r_halt      <= r_halt | w_set_halt;
      r_fetch_err <= r_fetch_err | w_set_err;
    end
  end

  assign io_ifu.imem_req_valid = r_req_valid;
  assign io_ifu.imem_req_addr  = r_pc;
  assign io_ifu.inst_valid     = r_inst_valid;
  assign io_ifu.inst           = r_inst;
  assign io_ifu.inst_pc        = r_inst_pc;
  assign io_ifu.halt           = r_halt;
  assign io_ifu.fetch_err      = r_fetch_err;

endmodule

// File: tb/tb_ysyx_22040365_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22040365_ifu
//
// Directed, table-driven bench for the instruction fetch unit. Each record
// holds the inputs for one cycle and the outputs expected during that cycle.
// Outputs are checked on the falling edge, then the record's inputs are
// driven for the next rising edge. Address is only compared while a request
// is expected, instruction/PC only while an instruction is expected.
// ---------------------------------------------------------------------------
module tb_ysyx_22040365_ifu;

  localparam logic [63:0] A    = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] EB   = 32'h0010_0073;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        re;
    logic        ir;
    logic        redv;
    logic [63:0] rpc;
    logic        erqv;
    logic [63:0] eaddr;
    logic        eiv;
    logic [31:0] einst;
    logic [63:0] eipc;
    logic        eh;
    logic        ee;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  ysyx_22040365_ifu_if bus ();

  ysyx_22040365_ifu #(
    .RESET_PC(64'h0000_0000_8000_0000)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_ifu(bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t V(input int rst_i, input int rdy, input int rv,
                             input logic [31:0] rd, input int re, input int ir,
                             input int redv, input logic [63:0] rpc,
                             input int erqv, input logic [63:0] eaddr,
                             input int eiv, input logic [31:0] einst,
                             input logic [63:0] eipc, input int eh, input int ee);
    vec_t v;
    v.rst   = (rst_i != 0);
    v.rdy   = (rdy != 0);
    v.rv    = (rv != 0);
    v.rd    = rd;
    v.re    = (re != 0);
    v.ir    = (ir != 0);
    v.redv  = (redv != 0);
    v.rpc   = rpc;
    v.erqv  = (erqv != 0);
    v.eaddr = eaddr;
    v.eiv   = (eiv != 0);
    v.einst = einst;
    v.eipc  = eipc;
    v.eh    = (eh != 0);
    v.ee    = (ee != 0);
    return v;
  endfunction

  // Check the current cycle's outputs, drive the record's inputs, advance.
  task automatic step(input vec_t v, input string tag);
    logic ok;
    checks++;
    ok = (bus.imem_req_valid === v.erqv) && (bus.inst_valid === v.eiv) &&
         (bus.halt === v.eh) && (bus.fetch_err === v.ee);
    if (v.erqv && (bus.imem_req_addr !== v.eaddr)) ok = 1'b0;
    if (v.eiv && ((bus.inst !== v.einst) || (bus.inst_pc !== v.eipc))) ok = 1'b0;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got rqv=%0b addr=%h iv=%0b inst=%h pc=%h halt=%0b err=%0b; want rqv=%0b addr=%h iv=%0b inst=%h pc=%h halt=%0b err=%0b",
               tag, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst,
               bus.inst_pc, bus.halt, bus.fetch_err, v.erqv, v.eaddr, v.eiv, v.einst,
               v.eipc, v.eh, v.ee);
    end
    rst                = v.rst;
    bus.imem_req_ready = v.rdy;
    bus.imem_rsp_valid = v.rv;
    bus.imem_rsp_data  = v.rd;
    bus.imem_rsp_err   = v.re;
    bus.inst_ready     = v.ir;
    bus.redirect_valid = v.redv;
    bus.redirect_pc    = v.rpc;
    @(negedge clk);
  endtask

  // Full reset-value comparison, no clock advance.
  task automatic chk_reset(input string tag);
    checks++;
    if ((bus.imem_req_valid !== 1'b0) || (bus.imem_req_addr !== A) ||
        (bus.inst_valid !== 1'b0) || (bus.inst !== NOP) || (bus.inst_pc !== A) ||
        (bus.halt !== 1'b0) || (bus.fetch_err !== 1'b0)) begin
      errors++;
      $display("FAIL %s: got rqv=%0b addr=%h iv=%0b inst=%h pc=%h halt=%0b err=%0b; want reset values",
               tag, bus.imem_req_valid, bus.imem_req_addr, bus.inst_valid, bus.inst,
               bus.inst_pc, bus.halt, bus.fetch_err);
    end
  endtask

  initial begin
    vec_t tbl[$];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = NOP;
    bus.imem_rsp_err   = 1'b0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = A;

    //              rst rdy rv rd    re ir rv rpc          rqv addr       iv inst  ipc       h  e
    // Fetch fault at A+8.
    tbl.push_back(V(1, 0, 0, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 1, 0, A,          0, A,          1, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h4,    0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, ADDI, 0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 1, 0, A,          0, A,          1, ADDI, A+64'h4,   0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h8,    0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  1, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 1, NOP,  0, 1, 1, A,          0, A,          0, NOP,  A,         0, 1));
    tbl.push_back(V(1, 0, 0, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 1));
    // Redirects in START, REQ+handshake, HOLD, WAIT, DROP; then misaligned.
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 1, A+64'h20,   0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 1, A+64'h40,   1, A+64'h20,   0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, EB,   1, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h40,   0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h80,   0, A,          1, NOP,  A+64'h40,  0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h80,   0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h60,   0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h70,   0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h102,  1, A+64'h70,   0, NOP,  A,         0, 0));
    tbl.push_back(V(1, 0, 0, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 1));
    // Sequential fetch, backpressure, redirect in WAIT, ebreak at A+0x10.
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 1, 0, A,          0, A,          1, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h4,    0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, ADDI, 0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(V(0, 1, 0, NOP, 0, 0, 0, A,         0, A,          1, ADDI, A+64'h4,   0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 1, 0, A,          0, A,          1, ADDI, A+64'h4,   0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h8,    0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h100,  0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, NOP,  0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h100,  0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, ADDI, 0, 0, 1, A+64'h200,  0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 0, 1, A+64'h10,   1, A+64'h200,  0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 1, 0, NOP,  0, 0, 0, A,          1, A+64'h10,   0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 1, EB,   0, 0, 0, A,          0, A,          0, NOP,  A,         0, 0));
    tbl.push_back(V(0, 0, 0, NOP,  0, 1, 0, A,          0, A,          1, EB,   A+64'h10,  0, 0));

    #2 rst = 1'b1;
    @(negedge clk);
    chk_reset("reset_state");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // After ebreak: halted, no requests for 20 cycles whatever the inputs do.
    for (int i = 0; i < 20; i++)
      step(V(0, 1, i % 2, NOP, 1, 1, 1, ((i % 3) == 0) ? A + 64'h2 : A + 64'h300,
             0, A, 0, NOP, A, 1, 0), $sformatf("halt_hold%0d", i));

    // Leave HALT via reset, then reset asynchronously in the middle of WAIT.
    step(V(1, 0, 0, NOP, 0, 0, 0, A, 0, A, 0, NOP, A, 1, 0), "halt_before_rst");
    step(V(0, 1, 0, NOP, 0, 0, 0, A, 0, A, 0, NOP, A, 0, 0), "start2");
    step(V(0, 1, 0, NOP, 0, 0, 0, A, 1, A, 0, NOP, A, 0, 0), "req2");
    step(V(0, 0, 1, ADDI, 0, 0, 0, A, 0, A, 0, NOP, A, 0, 0), "wait2");
    step(V(0, 0, 0, NOP, 0, 1, 0, A, 0, A, 1, ADDI, A, 0, 0), "hold2");
    step(V(0, 1, 0, NOP, 0, 0, 0, A, 1, A + 64'h4, 0, NOP, A, 0, 0), "req3");
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid_wait");
    @(negedge clk);
    step(V(0, 1, 0, NOP, 0, 0, 0, A, 0, A, 0, NOP, A, 0, 0), "start_after_rst");
    step(V(0, 0, 0, NOP, 0, 0, 0, A, 1, A, 0, NOP, A, 0, 0), "first_req_after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
